// File: rtl/alarm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alarm_pkg
//  Purpose  : Shared state encodings, alarm-cause bit positions and default
//             timing-counter width for the alarm controller.
//  Revision : 1.0  initial release
// ============================================================================
package alarm_pkg;

    localparam int c_DEFAULT_SIZE = 27;

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_ARMED   = 2'd1;
    localparam logic [1:0] c_ST_CONFIRM = 2'd2;
    localparam logic [1:0] c_ST_ALARM   = 2'd3;

    localparam int c_CAUSE_GAS = 0;
    localparam int c_CAUSE_MOV = 1;

endpackage
`default_nettype wire

// File: rtl/alarm_confirm_counter.sv
`default_nettype none
// ============================================================================
//  Module   : alarm_confirm_counter
//  Purpose  : Sensor persistence counter; confirm is raised on the LIMIT-th
//             consecutive enabled cycle with the input high.
//  Revision : 1.0  initial release
// ============================================================================
module alarm_confirm_counter
    import alarm_pkg::*;
#(
    parameter int              SIZE  = c_DEFAULT_SIZE,
    parameter logic [SIZE-1:0] LIMIT = SIZE'(100000000)
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic in,
    output logic confirm
);

    localparam logic [SIZE-1:0] c_LAST = LIMIT - SIZE'(1);

    logic [SIZE-1:0] r_count;
    logic            w_at_last;

    assign w_at_last = (r_count == c_LAST);
    assign confirm   = en & in & w_at_last;

    // Saturates at the last value so the count can never pass LIMIT-1.
    always_ff @(posedge clk) begin
        if (rst || !en || !in) begin
            r_count <= '0;
        end else if (!w_at_last) begin
            r_count <= r_count + SIZE'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/alarm_controller.sv
`default_nettype none
// ============================================================================
//  Module   : alarm_controller
//  Purpose  : Arm/confirm/alarm sequencer driving siren, message pulse and
//             status LED from synchronized board inputs.
//  Revision : 1.0  initial release
// ============================================================================
module alarm_controller
    import alarm_pkg::*;
#(
    parameter int              SIZE        = c_DEFAULT_SIZE,
    parameter logic [SIZE-1:0] TONE_HALF   = SIZE'(833333),
    parameter logic [SIZE-1:0] CONFIRM_GAS = SIZE'(100000000),
    parameter logic [SIZE-1:0] CONFIRM_MOV = SIZE'(100000000),
    parameter logic [SIZE-1:0] MSG_PULSE   = SIZE'(50)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw_on,
    input  logic       gases,
    input  logic       movimiento,
    input  logic       clave,
    output logic       sound,
    output logic       mensaje,
    output logic       clk_out,
    output logic [1:0] state,
    output logic [1:0] cause
);

    localparam logic [SIZE-1:0] c_TONE_LAST = TONE_HALF - SIZE'(1);
    localparam logic [SIZE-1:0] c_MSG_LAST  = MSG_PULSE - SIZE'(1);

    logic [1:0]      r_sw_pipe, r_gas_pipe, r_mov_pipe, r_clave_pipe;
    logic            r_clave_d;
    logic [1:0]      r_state;
    logic            r_rearm_ok;
    logic [SIZE-1:0] r_tone;
    logic [SIZE-1:0] r_msg_cnt;
    logic            r_sound, r_mensaje, r_clk_out;
    logic [1:0]      r_cause;

    logic            w_sw, w_gas, w_mov, w_clave, w_clave_rise;
    logic            w_en, w_gas_confirm, w_mov_confirm;
    logic [1:0]      w_next_state;
    logic            w_next_rearm;
    logic            w_change, w_wrap;
    logic [1:0]      w_cause_load;

    // Sensors idle low; the arm switch idles high, i.e. system off.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sw_pipe    <= 2'b11;
            r_gas_pipe   <= 2'b00;
            r_mov_pipe   <= 2'b00;
            r_clave_pipe <= 2'b00;
            r_clave_d    <= 1'b0;
        end else begin
            r_sw_pipe    <= {r_sw_pipe[0], sw_on};
            r_gas_pipe   <= {r_gas_pipe[0], gases};
            r_mov_pipe   <= {r_mov_pipe[0], movimiento};
            r_clave_pipe <= {r_clave_pipe[0], clave};
            r_clave_d    <= r_clave_pipe[1];
        end
    end

    assign w_sw         = r_sw_pipe[1];
    assign w_gas        = r_gas_pipe[1];
    assign w_mov        = r_mov_pipe[1];
    assign w_clave      = r_clave_pipe[1];
    assign w_clave_rise = w_clave & ~r_clave_d;
    assign w_en         = (r_state == c_ST_ARMED) || (r_state == c_ST_CONFIRM);

    alarm_confirm_counter #(.SIZE(SIZE), .LIMIT(CONFIRM_GAS)) u_gas_confirm (
        .clk     (clk),
        .rst     (rst),
        .en      (w_en),
        .in      (w_gas),
        .confirm (w_gas_confirm)
    );

    alarm_confirm_counter #(.SIZE(SIZE), .LIMIT(CONFIRM_MOV)) u_mov_confirm (
        .clk     (clk),
        .rst     (rst),
        .en      (w_en),
        .in      (w_mov),
        .confirm (w_mov_confirm)
    );

    // Priority: switch off, then disarm key, then confirm, then sensors clear.
    always_comb begin
        w_next_state = r_state;
        w_next_rearm = r_rearm_ok;
        if (w_sw) begin
            w_next_state = c_ST_IDLE;
            w_next_rearm = 1'b1;
        end else if ((r_state != c_ST_IDLE) && w_clave_rise) begin
            w_next_state = c_ST_IDLE;
            w_next_rearm = 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (r_rearm_ok && !w_clave) w_next_state = c_ST_ARMED;
                end
                c_ST_ARMED: begin
                    if (w_gas || w_mov) w_next_state = c_ST_CONFIRM;
                end
                c_ST_CONFIRM: begin
                    if (w_gas_confirm || w_mov_confirm) w_next_state = c_ST_ALARM;
                    else if (!w_gas && !w_mov)          w_next_state = c_ST_ARMED;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_cause_load              = 2'b00;
        w_cause_load[c_CAUSE_GAS] = w_gas_confirm;
        w_cause_load[c_CAUSE_MOV] = w_mov_confirm;
    end

    assign w_change = (w_next_state != r_state);
    assign w_wrap   = (r_tone == c_TONE_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_rearm_ok <= 1'b1;
            r_tone     <= '0;
            r_msg_cnt  <= '0;
            r_sound    <= 1'b0;
            r_mensaje  <= 1'b0;
            r_clk_out  <= 1'b0;
            r_cause    <= 2'b00;
        end else begin
            r_state    <= w_next_state;
            r_rearm_ok <= w_next_rearm;
            r_tone     <= (w_change || w_wrap) ? '0 : r_tone + SIZE'(1);

            // A state change restarts the tone phase, so it never toggles outputs.
            if (w_next_state != c_ST_ALARM || w_change) r_sound <= 1'b0;
            else if (w_wrap)                            r_sound <= ~r_sound;

            case (w_next_state)
                c_ST_IDLE:  r_clk_out <= 1'b0;
                c_ST_ALARM: r_clk_out <= 1'b1;
                default:    if (w_wrap && !w_change) r_clk_out <= ~r_clk_out;
            endcase

            if (w_next_state != c_ST_ALARM) begin
                r_mensaje <= 1'b0;
                r_msg_cnt <= '0;
            end else if (w_change) begin
                r_mensaje <= 1'b1;
                r_msg_cnt <= '0;
            end else if (r_mensaje) begin
                if (r_msg_cnt == c_MSG_LAST) r_mensaje <= 1'b0;
                else                         r_msg_cnt <= r_msg_cnt + SIZE'(1);
            end

            if (w_next_state == c_ST_IDLE)                 r_cause <= 2'b00;
            else if (w_next_state == c_ST_ALARM && w_change) r_cause <= w_cause_load;
        end
    end

    assign state   = r_state;
    assign sound   = r_sound;
    assign mensaje = r_mensaje;
    assign clk_out = r_clk_out;
    assign cause   = r_cause;

endmodule
`default_nettype wire
